// File: rtl/imem_loader_if.sv
// Byte-stream / instruction-memory write bus for the imem_loader.
// The slave side is the loader; the master side is whoever feeds program
// bytes and observes the memory writes (host logic or a testbench).
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 13
);
  // session control
  logic                  start;
  logic [ADDR_WIDTH:0]   word_count;
  logic                  abort;
  // byte stream
  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  // instruction-memory write port
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  // status
  logic                  busy;
  logic                  done;
  logic                  err;

  modport slave (
    input  start, word_count, abort, byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata, busy, done, err
  );

  modport master (
    output start, word_count, abort, byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata, busy, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a big-endian byte stream into 32-bit
// words and writes them to consecutive word addresses starting at 0.
// A session is opened by start with a word count, closed by done after the
// last write, or cut short by abort (sticky err, no partial-word write).
// All handshake/strobe outputs come straight from flops loaded with the
// decode of the next state, so nothing combinational reaches an output.
module imem_loader #(
  parameter int ADDR_WIDTH = 13,
  parameter int DEPTH      = 8192
) (
  input  logic          i_clk,
  input  logic          i_reset,
  imem_loader_if.slave  bus
);

  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LP_ONE   = (ADDR_WIDTH+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RECV   = 2'd1,
    S_WRITE  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH:0]   r_count;     // words requested for this session
  logic [ADDR_WIDTH-1:0] r_addr;      // address of the word being built
  logic [1:0]            r_idx;       // next byte lane, 0 = bits 31:24
  logic [31:0]           r_word;
  logic                  r_byte_ready;
  logic                  r_mem_we;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;

  logic                  w_accept;    // byte handshake completes this edge
  logic                  w_last;      // word at r_addr is the final one
  logic                  w_cnt_zero;
  logic                  w_cnt_ok;    // count fits in the memory

  // byte_ready is only ever high in RECV, so it doubles as the RECV qualifier
  assign w_accept   = r_byte_ready & bus.byte_valid;
  assign w_last     = (({1'b0, r_addr} + LP_ONE) == r_count);
  assign w_cnt_zero = (bus.word_count == '0);
  assign w_cnt_ok   = (bus.word_count <= LP_DEPTH);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state decode; abort wins over byte acceptance and write completion
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (w_cnt_zero)    w_next = S_FINISH;
          else if (w_cnt_ok) w_next = S_RECV;
        end
      end
      S_RECV: begin
        if (bus.abort)                        w_next = S_IDLE;
        else if (w_accept && r_idx == 2'd3)   w_next = S_WRITE;
      end
      S_WRITE: begin
        if (bus.abort)   w_next = S_IDLE;
        else if (w_last) w_next = S_FINISH;
        else             w_next = S_RECV;
      end
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Registered strobes/status, loaded from the next-state decode
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_byte_ready <= 1'b0;
      r_mem_we     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_byte_ready <= (w_next == S_RECV);
      r_mem_we     <= (w_next == S_WRITE);
      r_busy       <= (w_next == S_RECV) || (w_next == S_WRITE);
      r_done       <= (w_next == S_FINISH);
    end
  end

  // Session datapath: count latch, byte assembly, address advance, error flag
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
      r_addr  <= '0;
      r_idx   <= '0;
      r_word  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (w_cnt_ok) begin
              r_count <= bus.word_count;
              r_addr  <= '0;
              r_idx   <= '0;
              r_word  <= '0;
              r_err   <= 1'b0;
            end else begin
              r_err   <= 1'b1;
            end
          end
        end
        S_RECV: begin
          if (bus.abort) begin
            r_err <= 1'b1;
          end else if (w_accept) begin
            case (r_idx)
              2'd0:    r_word[31:24] <= bus.byte_in;
              2'd1:    r_word[23:16] <= bus.byte_in;
              2'd2:    r_word[15:8]  <= bus.byte_in;
              default: r_word[7:0]   <= bus.byte_in;
            endcase
            r_idx <= r_idx + 2'd1;
          end
        end
        S_WRITE: begin
          // The write itself is already on the bus this cycle; abort only
          // ends the session afterwards. The address holds on the final
          // word so it never steps past DEPTH-1.
          r_idx <= '0;
          if (!w_last) r_addr <= r_addr + 1'b1;
          if (bus.abort) r_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.byte_ready = r_byte_ready;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_addr;
  assign bus.mem_wdata  = r_word;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected memory writes are queued when the
// bytes are driven and popped by a negedge monitor whenever mem_we is high.
module tb_imem_loader;
  localparam int AW = 13;
  localparam int DP = 8192;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus();

  imem_loader #(.ADDR_WIDTH(AW), .DEPTH(DP)) dut (
    .i_clk  (clk),
    .i_reset(reset),
    .bus    (bus)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_asr  = 0;
  int  n_fail = 0;
  int  cyc    = 0;
  int  n_wr   = 0;
  int  n_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asr++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // write/done monitor
  always @(negedge clk) begin
    if (bus.done === 1'b1) n_done++;
    if (bus.mem_we === 1'b1) begin
      n_wr++;
      chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.mem_addr), 32'(mon_e.addr));
        chk("wr_data", bus.mem_wdata, mon_e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input int wc);
    bus.word_count = (AW+1)'(wc);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output int acc);
    bit ok;
    ok = 1'b0;
    bus.byte_in = b;
    bus.byte_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.byte_ready === 1'b1) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
    end
    acc = cyc;
    n_asr++;
    assert (ok) else begin
      n_fail++;
      $error("FAIL byte_accept: byte %h observed not accepted in 50 cycles, expected accepted", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    int a;
    send_byte(w[31:24], a);
    send_byte(w[23:16], a);
    send_byte(w[15:8], a);
    send_byte(w[7:0], a);
    bus.byte_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int at);
    bit ok;
    ok = 1'b0;
    at = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
    n_asr++;
    assert (ok) else begin
      n_fail++;
      $error("FAIL %s: observed no done within %0d cycles, expected done", tag, budget);
    end
    @(posedge clk); #1;
  endtask

  task automatic push(input int a, input logic [31:0] d);
    wr_t e;
    e.addr = AW'(a);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'd0);
    chk({tag, "_mem_we"},     32'(bus.mem_we),     32'd0);
    chk({tag, "_mem_addr"},   32'(bus.mem_addr),   32'd0);
    chk({tag, "_mem_wdata"},  bus.mem_wdata,       32'd0);
    chk({tag, "_busy"},       32'(bus.busy),       32'd0);
    chk({tag, "_done"},       32'(bus.done),       32'd0);
    chk({tag, "_err"},        32'(bus.err),        32'd0);
  endtask

  initial begin
    int p, at, a, wr0, dn0;
    logic [31:0] w;
    bus.start = 1'b0;
    bus.word_count = '0;
    bus.abort = 1'b0;
    bus.byte_in = '0;
    bus.byte_valid = 1'b0;

    // reset state
    tick(); tick();
    @(negedge clk);
    chk_reset_outs("rst");
    @(posedge clk); #1;
    reset = 1'b0;
    tick();

    // two back-to-back words, 10 cycles from first byte to FINISH
    push(0, 32'h8C220004);
    push(1, 32'hAC220008);
    wr0 = n_wr; dn0 = n_done;
    pulse_start(2);
    send_byte(8'h8C, p);
    send_byte(8'h22, a); send_byte(8'h00, a); send_byte(8'h04, a);
    send_byte(8'hAC, a); send_byte(8'h22, a); send_byte(8'h00, a); send_byte(8'h08, a);
    bus.byte_valid = 1'b0;
    wait_done("t2w_done", 20, at);
    chk("t2w_latency", 32'(at - p), 32'd9);
    chk("t2w_writes", 32'(n_wr - wr0), 32'd2);
    chk("t2w_done_cnt", 32'(n_done - dn0), 32'd1);
    chk("t2w_busy_after", 32'(bus.busy), 32'd0);

    // gapped bytes; byte_ready holds through the gaps
    push(0, 32'h12345678);
    wr0 = n_wr;
    pulse_start(1);
    for (int i = 0; i < 4; i++) begin
      w = 32'h12345678;
      send_byte(w[31-8*i -: 8], a);
      bus.byte_valid = 1'b0;
      if (i < 3) begin
        for (int g = 0; g < 3; g++) begin
          @(negedge clk);
          chk("gap_ready", 32'(bus.byte_ready), 32'd1);
          @(posedge clk); #1;
        end
      end
    end
    wait_done("gap_done", 20, at);
    chk("gap_writes", 32'(n_wr - wr0), 32'd1);

    // abort after 6 bytes of a 3-word load
    push(0, 32'hDEADBEEF);
    wr0 = n_wr; dn0 = n_done;
    pulse_start(3);
    send_word(32'hDEADBEEF);
    send_byte(8'h11, a); send_byte(8'h22, a);
    bus.byte_valid = 1'b0;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_err", 32'(bus.err), 32'd1);
    chk("abort_ready", 32'(bus.byte_ready), 32'd0);
    repeat (4) tick();
    chk("abort_writes", 32'(n_wr - wr0), 32'd1);
    chk("abort_no_done", 32'(n_done - dn0), 32'd0);

    // zero-word session: done on the 2nd cycle, err cleared by the start
    wr0 = n_wr;
    pulse_start(0);
    @(negedge clk);
    chk("zero_done", 32'(bus.done), 32'd1);
    chk("zero_busy", 32'(bus.busy), 32'd0);
    chk("zero_err_clr", 32'(bus.err), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("zero_done_1cyc", 32'(bus.done), 32'd0);
    @(posedge clk); #1;
    chk("zero_writes", 32'(n_wr - wr0), 32'd0);

    // oversize count: err, stays idle
    pulse_start(DP + 1);
    @(negedge clk);
    chk("big_err", 32'(bus.err), 32'd1);
    chk("big_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("big_busy2", 32'(bus.busy), 32'd0);
    chk("big_ready", 32'(bus.byte_ready), 32'd0);
    @(posedge clk); #1;

    // start while busy is ignored
    push(0, 32'h0A0B0C0D);
    push(1, 32'h01020304);
    wr0 = n_wr; dn0 = n_done;
    pulse_start(2);
    send_byte(8'h0A, a); send_byte(8'h0B, a);
    bus.word_count = (AW+1)'(1);
    bus.start = 1'b1;
    send_byte(8'h0C, a);
    bus.start = 1'b0;
    send_byte(8'h0D, a);
    bus.byte_valid = 1'b0;
    send_word(32'h01020304);
    wait_done("busy_start_done", 20, at);
    chk("busy_start_writes", 32'(n_wr - wr0), 32'd2);
    chk("busy_start_done_cnt", 32'(n_done - dn0), 32'd1);

    // reset mid-word, then a fresh single-word load
    wr0 = n_wr;
    pulse_start(1);
    send_byte(8'h55, a); send_byte(8'h66, a);
    bus.byte_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk_reset_outs("midrst");
    @(posedge clk); #1;
    chk("midrst_writes", 32'(n_wr - wr0), 32'd0);
    push(0, 32'hCAFEF00D);
    pulse_start(1);
    send_word(32'hCAFEF00D);
    wait_done("midrst_done", 20, at);
    chk("midrst_writes2", 32'(n_wr - wr0), 32'd1);

    // abort coinciding with WRITE: that write still happens
    push(0, 32'h76543210);
    wr0 = n_wr; dn0 = n_done;
    pulse_start(2);
    send_word(32'h76543210);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    @(negedge clk);
    chk("abw_err", 32'(bus.err), 32'd1);
    chk("abw_busy", 32'(bus.busy), 32'd0);
    repeat (3) tick();
    chk("abw_writes", 32'(n_wr - wr0), 32'd1);
    chk("abw_no_done", 32'(n_done - dn0), 32'd0);

    // full-depth load: every address 0..DEPTH-1 exactly once
    wr0 = n_wr; dn0 = n_done;
    pulse_start(DP);
    for (int i = 0; i < DP; i++) begin
      w = $urandom;
      push(i, w);
      send_word(w);
    end
    wait_done("full_done", 20, at);
    chk("full_writes", 32'(n_wr - wr0), 32'(DP));
    chk("full_done_cnt", 32'(n_done - dn0), 32'd1);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asr, n_fail);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 13, instruction-memory word-address width.
REQ-002 Parameter DEPTH, default 8192, number of 32-bit words in instruction memory.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a load session.
REQ-006 word_count  input  ADDR_WIDTH+1  number of words to load; sampled only on an accepted start.
REQ-007 abort  input  1  terminates an active session.
REQ-008 byte_in  input  8  incoming program byte.
REQ-009 byte_valid  input  1  byte_in holds a valid byte.
REQ-010 byte_ready  output  1  loader accepts byte_in this cycle.
REQ-011 mem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-012 mem_addr  output  ADDR_WIDTH  word address of the write.
REQ-013 mem_wdata  output  32  instruction word being written.
REQ-014 busy  output  1  session in progress.
REQ-015 done  output  1  one-cycle pulse when a session completes normally.
REQ-016 err  output  1  sticky error flag; cleared by reset or the next accepted start.

Function
REQ-017 The FSM SHALL have the states IDLE, RECV, WRITE and FINISH.
REQ-018 IDLE: start=1 with 1 <= word_count <= DEPTH SHALL latch word_count, clear mem_addr, the byte index and err, and enter RECV on the next edge.
REQ-019 IDLE: start=1 with word_count=0 SHALL enter FINISH with no write performed.
REQ-020 IDLE: start=1 with word_count > DEPTH SHALL set err, remain in IDLE and perform no write.
REQ-021 byte_ready SHALL be 1 only in RECV; a byte is accepted on an edge where byte_valid and byte_ready are both 1.
REQ-022 Bytes SHALL be assembled big-endian: the 1st accepted byte goes to bits 31:24, the 2nd to 23:16, the 3rd to 15:8 and the 4th to 7:0.
REQ-023 Acceptance of the 4th byte SHALL enter WRITE on the next edge.
REQ-024 WRITE SHALL last exactly one cycle, with mem_we=1, mem_wdata equal to the assembled word and mem_addr equal to the current word address.
REQ-025 Leaving WRITE SHALL increment mem_addr and reset the byte index.
REQ-026 Leaving WRITE SHALL enter FINISH when the written word is word number word_count, and RECV otherwise.
REQ-027 FINISH SHALL assert done for one cycle and then enter IDLE.
REQ-028 busy SHALL be 1 in RECV and WRITE, and 0 in IDLE and FINISH.
REQ-029 start SHALL be ignored in every state other than IDLE.
REQ-030 A gap of any length in byte_valid SHALL stall assembly without loss of the partial word.
REQ-031 Minimum throughput SHALL be 5 cycles per word: 4 bytes plus 1 write cycle.
REQ-032 abort=1 in RECV or WRITE SHALL enter IDLE on the next edge and set err.
REQ-033 On abort, no mem_we pulse SHALL occur for the partial word, and done SHALL not assert.
REQ-034 If abort and a WRITE cycle coincide, that write SHALL still occur (mem_we=1 in that cycle), and the session SHALL then end as in REQ-032 and REQ-033.
REQ-035 abort in IDLE or FINISH SHALL have no effect.
REQ-036 mem_addr SHALL never exceed DEPTH-1; word_count=DEPTH writes addresses 0 through DEPTH-1 exactly once.
REQ-037 mem_we, done and byte_ready SHALL be registered outputs with no combinational path from any input.

Reset
REQ-038 Reset SHALL force IDLE and set byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0 and err=0.
REQ-039 Reset SHALL take priority over start and abort in the same cycle.
REQ-040 Reset asserted mid-session SHALL discard the partial word; no write occurs in the cycle after reset.

Verification
REQ-041 start with word_count=2, then bytes 8C,22,00,04,AC,22,00,08 with byte_valid held 1 -> mem_we at addr 0 with data 8C220004, then at addr 1 with data AC220008; done pulses once; total 10 cycles from the first byte.
REQ-042 start with word_count=1; bytes 12,34,56,78 each separated by 3 idle cycles -> a single write of 12345678 at addr 0; byte_ready stays 1 through the gaps.
REQ-043 start with word_count=3; abort after 6 bytes -> exactly one write (addr 0), err=1, done never asserts, busy=0 the next cycle.
REQ-044 start with word_count=0 -> done pulses on the 2nd cycle and no mem_we; start with word_count=8193 -> err=1, busy remains 0.
REQ-045 start pulsed while busy during a 2-word load -> ignored; mem_addr sequence remains 0,1.
REQ-046 reset asserted after 2 bytes of word 0 -> all outputs return to their reset values on the next edge; a new start with word_count=1 writes at addr 0 correctly.
